// File: rtl/modular_unit_if.sv
// Start/done bus of modular_unit. When MODULAR_QUOTIENT_EN is defined the bus
// also carries the quotient.
interface modular_unit_if #(
  parameter int WIDTH = 32
);
  logic             modular_ready;
  logic [WIDTH-1:0] numerator;
  logic [WIDTH-1:0] denominator;
  logic             modular_done;
  logic [WIDTH-1:0] result;
`ifdef MODULAR_QUOTIENT_EN
  logic [WIDTH-1:0] quotient;

  modport master (output modular_ready, numerator, denominator,
                  input  modular_done, result, quotient);
  modport slave  (input  modular_ready, numerator, denominator,
                  output modular_done, result, quotient);
`else
  modport master (output modular_ready, numerator, denominator,
                  input  modular_done, result);
  modport slave  (input  modular_ready, numerator, denominator,
                  output modular_done, result);
`endif
endinterface

// File: rtl/modular_unit.sv
// Sequential unsigned numerator mod denominator using restoring shift-subtract, one bit per clock.
// Optional macro MODULAR_QUOTIENT_EN adds the quotient output.
module modular_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,      // active-high asynchronous reset despite the name
  modular_unit_if.slave bus,
  output logic [1:0] dbg_state
);
  // Handshake: modular_ready is a level. It is sampled only in IDLE, where a 1
  // latches the operands. modular_done rises WIDTH edges later and holds with
  // result until modular_ready is seen low. That edge clears done and returns to IDLE.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    count;
  logic             done_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH:0]   rem_next;
  logic             last_iter;

  // The partial remainder is always below the divisor, so rem[WIDTH] is zero
  // before the shift and dropping it loses nothing.
  always_comb begin
    shifted   = {rem[WIDTH-1:0], dividend[WIDTH-1]};
    take      = (shifted >= {1'b0, divisor});
    rem_next  = take ? (shifted - {1'b0, divisor}) : shifted;
    last_iter = (count == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.modular_ready)  state_next = CALC;
      CALC:    if (last_iter)          state_next = DONE;
      DONE:    if (!bus.modular_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= IDLE;
    else         state <= state_next;
  end

`ifdef MODULAR_QUOTIENT_EN
  logic [WIDTH-1:0] quotient_r;
`endif

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      dividend   <= '0;
      divisor    <= '0;
      rem        <= '0;
      count      <= '0;
      done_r     <= 1'b0;
      result_r   <= '0;
`ifdef MODULAR_QUOTIENT_EN
      quotient_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.modular_ready) begin
            dividend <= bus.numerator;
            divisor  <= bus.denominator;
            rem      <= '0;
            count    <= '0;
          end
        end
        CALC: begin
          // Quotient bits shift into the vacated low end of the dividend.
          dividend <= {dividend[WIDTH-2:0], take};
          rem      <= rem_next;
          count    <= count + 1'b1;
          if (last_iter) begin
            result_r   <= rem_next[WIDTH-1:0];
            done_r     <= 1'b1;
`ifdef MODULAR_QUOTIENT_EN
            quotient_r <= {dividend[WIDTH-2:0], take};
`endif
          end
        end
        DONE: begin
          if (!bus.modular_ready) done_r <= 1'b0;
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign bus.modular_done = done_r;
  assign bus.result       = result_r;
`ifdef MODULAR_QUOTIENT_EN
  assign bus.quotient     = quotient_r;
`endif
  assign dbg_state        = state;
endmodule

// File: tb/tb_modular_unit.sv
// Self-checking bench for modular_unit: expected remainders (and quotients when
// MODULAR_QUOTIENT_EN is defined) are queued at start and popped at done.
module tb_modular_unit;
  localparam int W = 32;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;

  modular_unit_if #(.WIDTH(W)) bus ();

  modular_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
`ifdef MODULAR_QUOTIENT_EN
  logic [W-1:0] exp_quo_q[$];
`endif
  logic [W-1:0] last_rem;

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] n, input logic [W-1:0] d);
    return (d == '0) ? n : n % d;
  endfunction

  function automatic logic [W-1:0] ref_quo(input logic [W-1:0] n, input logic [W-1:0] d);
    return (d == '0) ? '1 : n / d;
  endfunction

  // Starts an operation and waits for done; checks latency and the popped expectation.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input bit scramble);
    int lat;
    bit seen;
    logic [W-1:0] exp_r;
    @(negedge clk);
    bus.numerator     = n;
    bus.denominator   = d;
    bus.modular_ready = 1'b1;
    exp_q.push_back(ref_rem(n, d));
`ifdef MODULAR_QUOTIENT_EN
    exp_quo_q.push_back(ref_quo(n, d));
`endif
    @(posedge clk);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      #1;
      if (scramble) begin
        bus.numerator   = $urandom;
        bus.denominator = $urandom;
      end
      @(posedge clk);
      lat++;
      #1;
      if (bus.modular_done) seen = 1'b1;
    end
    vectors++;
    if (!seen || lat != W) begin
      $display("FAIL latency n=%0d d=%0d: got %0d edges (seen=%0b), want %0d", n, d, lat, seen, W);
      miscompares++;
    end
    if (exp_q.size() != 0) begin
      exp_r = exp_q.pop_front();
      last_rem = exp_r;
      vectors++;
      if (bus.result !== exp_r) begin
        $display("FAIL result n=%0d d=%0d: got %0d, want %0d", n, d, bus.result, exp_r);
        miscompares++;
      end
    end
`ifdef MODULAR_QUOTIENT_EN
    if (exp_quo_q.size() != 0) begin
      exp_r = exp_quo_q.pop_front();
      vectors++;
      if (bus.quotient !== exp_r) begin
        $display("FAIL quotient n=%0d d=%0d: got %0d, want %0d", n, d, bus.quotient, exp_r);
        miscompares++;
      end
    end
`endif
  endtask

  task automatic drop_ready();
    @(negedge clk);
    bus.modular_ready = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.modular_done !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL release: done=%0b state=%0d, want done=0 state=0", bus.modular_done, dbg_state);
      miscompares++;
    end
    vectors++;
    if (bus.result !== last_rem) begin
      $display("FAIL result_kept: got %0d, want %0d", bus.result, last_rem);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.modular_ready = 1'b0;
    bus.numerator     = '0;
    bus.denominator   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.modular_done !== 1'b0 || bus.result !== '0 || dbg_state !== 2'd0) begin
      $display("FAIL reset_state: done=%0b result=%0d state=%0d, want 0/0/0",
               bus.modular_done, bus.result, dbg_state);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    run_op(32'd234328, 32'd273, 1'b0);
    // Ready held high: unit must sit in DONE without restarting.
    repeat (3) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.modular_done !== 1'b1 || bus.result !== 32'd94 || dbg_state !== 2'd2) begin
        $display("FAIL done_hold: done=%0b result=%0d state=%0d, want 1/94/2",
                 bus.modular_done, bus.result, dbg_state);
        miscompares++;
      end
    end
    drop_ready();
  endtask

  task automatic test_handshake();
    run_op(32'd556, 32'd27, 1'b0);
    drop_ready();
    run_op(32'd1000, 32'd7, 1'b0);
    drop_ready();
  endtask

  task automatic test_boundaries();
    logic [W-1:0] nums [5] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1234};
    logic [W-1:0] dens [5] = '{32'd9, 32'hFFFF_FFFF, 32'd10,        32'h8000_0000, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(nums[i], dens[i], 1'b0);
      drop_ready();
    end
  endtask

  task automatic test_operand_change();
    run_op(32'd987654321, 32'd12345, 1'b1);
    drop_ready();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] n, d;
    for (int i = 0; i < 8; i++) begin
      n = $urandom;
      d = (i % 3 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      run_op(n, d, 1'b0);
      drop_ready();
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.numerator     = 32'd777;
    bus.denominator   = 32'd5;
    bus.modular_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.modular_ready = 1'b0;
    #1;
    vectors++;
    if (bus.modular_done !== 1'b0 || bus.result !== '0 || dbg_state !== 2'd0) begin
      $display("FAIL mid_reset: done=%0b result=%0d state=%0d, want 0/0/0",
               bus.modular_done, bus.result, dbg_state);
      miscompares++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if (bus.modular_done !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL aborted_op: done=%0b state=%0d, want 0/0", bus.modular_done, dbg_state);
      miscompares++;
    end
    last_rem = '0;
    run_op(32'd777, 32'd5, 1'b0);
    drop_ready();
  endtask

  initial begin
    last_rem = '0;
    test_reset();
    test_basic();
    test_handshake();
    test_boundaries();
    test_operand_change();
    test_back_to_back();
    test_mid_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL leftover_expectations: got %0d queued, want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
